// File: rtl/mux_nto1_reg_if.sv
// mux_nto1_reg_if: channel inputs, select controls and registered output bundle for mux_nto1_reg.
// out_par is present only when MUX_PARITY_EN is defined.
interface mux_nto1_reg_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_valid;
  logic                      out_ready;
  logic                      sel_err;
`ifdef MUX_PARITY_EN
  logic                      out_par;
  modport master (output in_data, in_valid, mode, sel, out_ready,
                  input in_ready, out_data, out_sel, out_valid, sel_err, out_par);
  modport slave  (input in_data, in_valid, mode, sel, out_ready,
                  output in_ready, out_data, out_sel, out_valid, sel_err, out_par);
`else
  modport master (output in_data, in_valid, mode, sel, out_ready,
                  input in_ready, out_data, out_sel, out_valid, sel_err);
  modport slave  (input in_data, in_valid, mode, sel, out_ready,
                  output in_ready, out_data, out_sel, out_valid, sel_err);
`endif
endinterface

// File: rtl/mux_nto1_reg.sv
// mux_nto1_reg: registered N-to-1 valid/ready mux, manual select or round-robin scan.
// Defining MUX_PARITY_EN adds a registered even-parity bit out_par alongside out_data.
module mux_nto1_reg #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input logic          clk,
  input logic          rst_n,
  mux_nto1_reg_if.slave bus
);
  localparam int SPAN = 1 << SEL_W;
  // Bit k set when select value k names a real channel; all ones for power-of-two CHANNELS.
  localparam logic [SPAN-1:0] SEL_OK = {SPAN{1'b1}} >> (SPAN - CHANNELS);
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] cand;
  logic             hit;
  logic             space;
  logic             take;
  logic [WIDTH-1:0] word;
  function automatic logic [SEL_W-1:0] wrap(input int p);
    return SEL_W'(p >= CHANNELS ? p - CHANNELS : p);
  endfunction
  assign space = rst_n && (!bus.out_valid || bus.out_ready);
  // Scan walks backwards so the nearest valid channel after ptr is the last one written.
  always_comb begin
    cand = '0;
    hit  = 1'b0;
    if (bus.mode) begin
      for (int i = CHANNELS; i >= 1; i--) begin
        if (bus.in_valid[wrap(int'(ptr) + i)]) begin
          cand = wrap(int'(ptr) + i);
          hit  = 1'b1;
        end
      end
    end else begin
      hit  = SEL_OK[bus.sel];
      cand = SEL_OK[bus.sel] ? bus.sel : '0;
    end
  end
  assign take         = hit && space && bus.in_valid[cand];
  assign word         = bus.in_data[cand*WIDTH +: WIDTH];
  assign bus.in_ready = (hit && space) ? {{(CHANNELS-1){1'b0}}, 1'b1} << cand : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      bus.out_valid <= 1'b0;
      bus.sel_err   <= 1'b0;
      ptr           <= SEL_W'(CHANNELS - 1);
    end else begin
      if (take) begin
        bus.out_data  <= word;
        bus.out_sel   <= cand;
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (take && bus.mode) ptr <= cand;
      bus.sel_err <= !bus.mode && !SEL_OK[bus.sel];
    end
  end
`ifdef MUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.out_par <= 1'b0;
    else if (take) bus.out_par <= ^word;
  end
`endif
endmodule

// File: tb/tb_mux_nto1_reg.sv
// tb_mux_nto1_reg: drives a 16-channel and a 10-channel mux with shared stimulus and
// compares both against a cycle-level reference model.
module tb_mux_nto1_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mux_nto1_reg_if #(.WIDTH(16), .CHANNELS(16)) a ();
  mux_nto1_reg_if #(.WIDTH(16), .CHANNELS(10)) b ();
  mux_nto1_reg #(.WIDTH(16), .CHANNELS(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  mux_nto1_reg #(.WIDTH(16), .CHANNELS(10)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));
  logic [255:0] din;
  logic [15:0]  vin;
  logic         mode;
  logic [3:0]   sel;
  logic         ordy;
  assign a.in_data   = din;
  assign b.in_data   = din[159:0];
  assign a.in_valid  = vin;
  assign b.in_valid  = vin[9:0];
  assign a.mode      = mode;
  assign b.mode      = mode;
  assign a.sel       = sel;
  assign b.sel       = sel;
  assign a.out_ready = ordy;
  assign b.out_ready = ordy;
  int n_chk = 0;
  int n_pass = 0;
  int nch[2] = '{16, 10};
  int mv[2], mdat[2], msel[2], mptr[2], merr[2], cand[2];
  bit acc[2];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic int pick(input int d);
    if (!mode) return (int'(sel) < nch[d]) ? int'(sel) : -1;
    for (int i = 1; i <= nch[d]; i++) begin
      int k = (mptr[d] + i) % nch[d];
      if (vin[k]) return k;
    end
    return -1;
  endfunction
  task automatic model_reset;
    for (int d = 0; d < 2; d++) begin
      mv[d] = 0; mdat[d] = 0; msel[d] = 0; merr[d] = 0; mptr[d] = nch[d] - 1;
    end
  endtask
  task automatic check_regs;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("out_valid[%0d]", d), d == 0 ? a.out_valid : b.out_valid, 64'(mv[d]));
      check($sformatf("out_data[%0d]", d), d == 0 ? a.out_data : b.out_data, 64'(mdat[d]));
      check($sformatf("out_sel[%0d]", d), d == 0 ? a.out_sel : b.out_sel, 64'(msel[d]));
      check($sformatf("sel_err[%0d]", d), d == 0 ? a.sel_err : b.sel_err, 64'(merr[d]));
`ifdef MUX_PARITY_EN
      check($sformatf("out_par[%0d]", d), d == 0 ? a.out_par : b.out_par, 64'(^mdat[d]));
`endif
    end
  endtask
  task automatic tick;
    #1;
    for (int d = 0; d < 2; d++) begin
      bit space = (mv[d] == 0) || ordy;
      logic [63:0] exp = (cand[d] >= 0 || 1) ? 64'(0) : 64'(0);
      cand[d] = pick(d);
      exp = (cand[d] >= 0 && space) ? (64'(1) << cand[d]) : 64'(0);
      check($sformatf("in_ready[%0d]", d), d == 0 ? 64'(a.in_ready) : 64'(b.in_ready), exp);
      acc[d] = (cand[d] >= 0 && space) ? vin[cand[d]] : 1'b0;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (acc[d]) begin
        mdat[d] = int'(din[cand[d]*16 +: 16]);
        msel[d] = cand[d];
        mv[d]   = 1;
        if (mode) mptr[d] = cand[d];
      end else if (ordy) begin
        mv[d] = 0;
      end
      merr[d] = (!mode && int'(sel) >= nch[d]) ? 1 : 0;
    end
    @(negedge clk);
    check_regs();
  endtask
  initial begin
    din = '0; vin = '0; mode = 1'b0; sel = '0; ordy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_regs();
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) din[k*16 +: 16] = 16'(k);
    vin = '1; mode = 1'b0; sel = 4'hB; ordy = 1'b1;
    #1 check("basic_ready", a.in_ready, 16'h0800);
    tick();
    check("basic_data", a.out_data, 16'h000B);
    check("basic_sel", a.out_sel, 11);
    mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("rot_sel", a.out_sel, 64'(i % 16));
      check("rot_valid", a.out_valid, 1);
    end
    mode = 1'b0; sel = 4'd5;
    tick();
    check("bp_load", a.out_data, 16'h0005);
    ordy = 1'b0;
    din[5*16 +: 16] = 16'h1234;
    repeat (3) begin
      tick();
      check("bp_data", a.out_data, 16'h0005);
      check("bp_valid", a.out_valid, 1);
      check("bp_ready", a.in_ready, 0);
    end
    ordy = 1'b1;
    tick();
    check("bp_refill", a.out_data, 16'h1234);
    tick();
    sel = 4'd12;
    tick();
    check("oor_valid", b.out_valid, 0);
    check("oor_err", b.sel_err, 1);
    mode = 1'b1; vin = '0;
    tick();
    check("oor_err_pulse", b.sel_err, 0);
    mode = 1'b0; sel = 4'd7; vin = '1; ordy = 1'b0;
    tick();
    check("rst_pre_valid", a.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", a.out_valid, 0);
    check("rst_ready", a.in_ready, 0);
    model_reset();
    @(negedge clk);
    check_regs();
    rst_n = 1'b1;
    mode = 1'b1; ordy = 1'b1;
    tick();
    check("rst_first", a.out_sel, 0);
`ifdef MUX_PARITY_EN
    mode = 1'b0; sel = 4'd3; din[3*16 +: 16] = 16'h0007;
    tick();
    check("par_7", a.out_par, 1);
`endif
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    vin = 16'h0204; mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("skip_sel", a.out_sel, (i % 2) ? 9 : 2);
    end
    repeat (600) begin
      for (int i = 0; i < 8; i++) din[i*32 +: 32] = $urandom;
      case ($urandom_range(0, 3))
        0: vin = '1;
        1: vin = 16'($urandom);
        2: vin = 16'($urandom & $urandom & $urandom);
        default: vin = '0;
      endcase
      mode = $urandom_range(0, 2) != 0;
      sel  = 4'($urandom);
      ordy = $urandom_range(0, 3) != 0;
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mux_nto1_reg.md
# mux_nto1_reg

Parametrised, registered N-to-1 channel multiplexer with per-channel valid/ready handshakes. It selects either the channel named by `sel` (manual mode) or the next pending channel in round-robin order (scan mode). The chosen word is forwarded through a single output register at full throughput. It is the successor to the fixed 16-way combinational select and is intended to merge several producer streams into one datapath consumer.

## Interface
Parameters:
- `WIDTH`, 16: data width per channel.
- `CHANNELS`, 16: number of input channels, 2..64.
- `SEL_W`, `$clog2(CHANNELS)`: select width. Derived; do not override.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_data`, input, CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid`, input, CHANNELS: per-channel valid.
- `in_ready`, output, CHANNELS: per-channel ready. At most one bit is high in any cycle (one-hot or zero).
- `mode`, input, 1: 0 = manual (use `sel`), 1 = round-robin scan.
- `sel`, input, SEL_W: channel select, used in manual mode only.
- `out_data`, output, WIDTH: registered selected word.
- `out_sel`, output, SEL_W: channel index of `out_data`.
- `out_valid`, output, 1: output register holds a word.
- `out_ready`, input, 1: consumer accepts the word.
- `sel_err`, output, 1: registered 1-cycle pulse when manual `sel` ≥ CHANNELS.

## Operation
- `space` = !out_valid || out_ready.
- **Chosen channel `c`:**
  - Manual mode: `c` = `sel` if `sel` < CHANNELS; otherwise there is no candidate.
  - Scan mode: `c` is the first k with `in_valid[k]`=1, searching from (`ptr`+1) mod CHANNELS upward with wrap. There is no candidate if all valids are 0.
- **in_ready:** `in_ready[c]` = `space` when a candidate exists; all other bits are 0. `in_ready` does not depend on `in_valid[c]` in manual mode. In scan mode it depends on the whole `in_valid` vector; this combinational path is documented.
- **Accept:** `in_valid[c] && in_ready[c]`. On accept:
  - `out_data` ← channel c data, `out_sel` ← c, `out_valid` ← 1.
  - In scan mode, `ptr` ← c.
- **Drain without refill:** `out_valid && out_ready` with no accept → `out_valid` ← 0. `out_data` and `out_sel` hold their last values.
- **Stall:** `out_valid && !out_ready` → `out_data`, `out_sel` and `out_valid` hold. All `in_ready` bits are 0.
- **`ptr` updates:** only on an accept in scan mode. Manual-mode accepts leave `ptr` unchanged.
- **Mode switching:** `mode` and `sel` are sampled every cycle. A change takes effect in the same cycle's selection, and a word already in the output register is unaffected. Switching to scan resumes from the stored `ptr`.
- **Out-of-range select:** manual mode with `sel` ≥ CHANNELS gives no accept and `sel_err`=1 in the next cycle. This holds only when CHANNELS is not a power of two.
- **Reset values:** `out_valid`=0, `out_data`=0, `out_sel`=0, `sel_err`=0, `ptr`=CHANNELS-1, so the first scan search starts at channel 0.

## Timing
- Latency: accept in cycle n → `out_valid`=1 with the data in cycle n+1.
- Throughput: one word per cycle while `out_ready`=1 (simultaneous drain and refill).
- Scan fairness: with all channels continuously valid and `out_ready`=1, grants follow 0,1,…,CHANNELS-1,0,… with no repeats inside a rotation.
- Reset mid-transfer: asserting `rst_n` low clears `out_valid` immediately, without waiting for a clock edge. The held word is lost, and `in_ready` drops to 0 while reset is held.
- Reset release: the first accept can occur on the first rising edge after `rst_n` deasserts.

## Configuration
- **`MUX_PARITY_EN` defined:**
  - Adds output port `out_par` (1 bit), the even parity (XOR reduction) of the selected word.
  - `out_par` is registered together with `out_data` and follows identical load, hold and drain rules.
  - Reset value is 0.
- **Not defined:**
  - The `out_par` port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- **Manual basic:** CHANNELS=16, WIDTH=16; channel k data = 16'h0000+k, all valid; `mode`=0, `sel`=4'hB, `out_ready`=1 → next cycle `out_data`=16'h000B, `out_sel`=11, only `in_ready[11]` high.
- **Scan rotation:** all 16 channels valid, `mode`=1, `out_ready`=1 for 20 cycles → `out_sel` sequence 0..15,0..3, one word per cycle, no gaps.
- **Scan skip:** only channels 2 and 9 valid, `ptr` at reset → grants 2, 9, 2, 9; channels without valid never get `in_ready`.
- **Backpressure:** `out_ready`=0 for 3 cycles after a load of 16'h0005 → `out_data` holds 16'h0005, `out_valid`=1, all `in_ready`=0. `out_ready`=1 → a new word loads the same cycle.
- **Out-of-range select:** CHANNELS=10, `mode`=0, `sel`=12 → no accept, `out_valid` stays 0, `sel_err`=1 for exactly one cycle after each such cycle.
- **Async reset:** assert `rst_n`=0 mid-cycle while `out_valid`=1 → `out_valid`=0 before the next edge. After release, scan grants channel 0 first. With `MUX_PARITY_EN`: data 16'h0007 → `out_par`=1.
